vme_master_transfer: RTL and testbench

VME_MASTER_TRANSFER -- requirements
Module: vme_master_transfer

---
 rtl/vme_pkg.sv | 59 +++++
 rtl/vme_sync.sv | 24 ++
 rtl/vme_master_transfer.sv | 185 ++++++++++++++++++
 tb/tb_vme_master_transfer.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/vme_pkg.sv
// Shared encodings for the VME master transfer block: FSM states, address
// spaces, address-modifier codes, strobe polarity and transceiver directions.
package vme_pkg;

    localparam logic [2:0] ST_IDLE         = 3'b000;
    localparam logic [2:0] ST_ADDRESS      = 3'b001;
    localparam logic [2:0] ST_DATA         = 3'b010;
    localparam logic [2:0] ST_WAIT_FOR_CPU = 3'b011;

    localparam logic [1:0] AS_A16  = 2'b00;
    localparam logic [1:0] AS_A24  = 2'b01;
    localparam logic [1:0] AS_A32  = 2'b10;
    localparam logic [1:0] AS_RSVD = 2'b11;

    localparam logic ACTIVE   = 1'b0;
    localparam logic INACTIVE = 1'b1;
    localparam logic DIR_IN   = 1'b1;
    localparam logic DIR_OUT  = 1'b0;

    localparam logic [5:0] AM_IDLE       = 6'h3F;
    localparam logic [5:0] AM_A16_USER   = 6'h29;
    localparam logic [5:0] AM_A16_SUPER  = 6'h2D;
    localparam logic [2:0] AM_A24_PREFIX = 3'b111;
    localparam logic [2:0] AM_A32_PREFIX = 3'b001;

    localparam logic [1:0] DSACK_32   = 2'b00;
    localparam logic [1:0] DSACK_16   = 2'b01;
    localparam logic [1:0] DSACK_NONE = 2'b11;
    localparam logic [1:0] DS_NONE    = 2'b11;

    // Attributes of the current cycle, captured when leaving IDLE.
    typedef struct packed {
        logic       write;
        logic       d32;
        logic [1:0] ds;
        logic [5:0] am;
        logic       dir;
    } cycle_t;

    localparam cycle_t CYCLE_IDLE = '{write: 1'b0, d32: 1'b0, ds: DS_NONE,
                                      am: AM_IDLE, dir: DIR_OUT};

    function automatic logic fc_legal(input logic [2:0] fc);
        return (fc == 3'b001) || (fc == 3'b010) || (fc == 3'b101) || (fc == 3'b110);
    endfunction

    // A24/A32 codes carry the function code in their low three bits.
    function automatic logic [5:0] am_code(input logic [1:0] space, input logic [2:0] fc);
        logic [5:0] am;
        case (space)
            AS_A16:  am = fc[2] ? AM_A16_SUPER : AM_A16_USER;
            AS_A24:  am = {AM_A24_PREFIX, fc};
            AS_A32:  am = {AM_A32_PREFIX, fc};
            default: am = AM_IDLE;
        endcase
        return am;
    endfunction

endpackage

// File: rtl/vme_sync.sv
// Multi-flop synchroniser for one asynchronous active-low input; resets to
// the inactive level so a reset never looks like a request.
module vme_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clock,
    input  logic reset,
    input  logic async_i,
    output logic sync_o
);

    logic [SYNC_STAGES-1:0] chain_q;

    always_ff @(posedge clock) begin
        if (!reset) begin
            chain_q <= '1;
        end else begin
            chain_q <= {chain_q[SYNC_STAGES-2:0], async_i};
        end
    end

    assign sync_o = chain_q[SYNC_STAGES-1];

endmodule

// File: rtl/vme_master_transfer.sv
// VME bus master cycle controller bridging a 68k-style CPU cycle onto VME.
// Define VME_BUS_TIMEOUT_EN to add a bus watchdog of TIMEOUT_CYCLES clocks.
module vme_master_transfer
    import vme_pkg::*;
#(
    parameter int SYNC_STAGES    = 2,
    parameter int D32_SUPPORT    = 1,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       request_vme,
    input  logic [1:0] addr_space,
    input  logic       bus_acquired,
    input  logic       cpu_ds,
    input  logic       cpu_write,
    input  logic [1:0] cpu_siz,
    input  logic [1:0] cpu_address,
    input  logic [2:0] cpu_fc,
    output logic [1:0] cpu_dsack,
    output logic       cpu_berr,
    output logic       vme_as,
    output logic [1:0] vme_ds,
    output logic       vme_lword,
    output logic       vme_write,
    output logic [5:0] vme_address_mod,
    input  logic       vme_dtack,
    input  logic       vme_berr,
    output logic       addr_oe,
    output logic       data_low_oe,
    output logic       data_high_oe,
    output logic       data_low_dir,
    output logic       data_high_dir,
    output logic       busy
);

    logic req_s, grant_s, cpu_ds_s, dtack_s, vberr_s;

    vme_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_req   (.clock(clock), .reset(reset), .async_i(request_vme),  .sync_o(req_s));
    vme_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_grant (.clock(clock), .reset(reset), .async_i(bus_acquired), .sync_o(grant_s));
    vme_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_ds    (.clock(clock), .reset(reset), .async_i(cpu_ds),       .sync_o(cpu_ds_s));
    vme_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_dtack (.clock(clock), .reset(reset), .async_i(vme_dtack),    .sync_o(dtack_s));
    vme_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_berr  (.clock(clock), .reset(reset), .async_i(vme_berr),     .sync_o(vberr_s));

    logic [2:0] state_q, state_d;
    cycle_t     cycle_q, cycle_d;
    logic [1:0] dsack_q, dsack_d;
    logic       berr_q, berr_d;
    logic       timeout;

    logic       d32_sel;
    logic [1:0] ds_sel;

    always_comb begin
        d32_sel = (D32_SUPPORT != 0) && (cpu_siz == 2'b00) && (cpu_address == 2'b00);
        if (d32_sel) begin
            ds_sel = 2'b00;
        end else if (cpu_siz == 2'b01) begin
            ds_sel = cpu_address[0] ? 2'b10 : 2'b01;
        end else begin
            ds_sel = 2'b00;
        end
    end

`ifdef VME_BUS_TIMEOUT_EN
    localparam int TIMER_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [TIMER_W-1:0] timer_q, timer_d;

    // Watchdog only runs while the VME bus is held; fires on the
    // TIMEOUT_CYCLES-th such cycle.
    always_comb begin
        timer_d = '0;
        timeout = 1'b0;
        if (state_q == ST_ADDRESS || state_q == ST_DATA) begin
            timer_d = timer_q + 1'b1;
            timeout = (timer_d == TIMER_W'(TIMEOUT_CYCLES));
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            timer_q <= '0;
        end else begin
            timer_q <= timer_d;
        end
    end
`else
    assign timeout = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        cycle_d = cycle_q;
        dsack_d = dsack_q;
        berr_d  = berr_q;
        case (state_q)
            ST_IDLE: begin
                if (req_s == ACTIVE) begin
                    if (!fc_legal(cpu_fc) || addr_space == AS_RSVD) begin
                        state_d = ST_WAIT_FOR_CPU;
                        berr_d  = ACTIVE;
                    end else if (grant_s == ACTIVE && dtack_s == INACTIVE && vberr_s == INACTIVE) begin
                        state_d       = ST_ADDRESS;
                        cycle_d.write = (cpu_write == ACTIVE);
                        cycle_d.d32   = d32_sel;
                        cycle_d.ds    = ds_sel;
                        cycle_d.am    = am_code(addr_space, cpu_fc);
                        cycle_d.dir   = (cpu_write == ACTIVE) ? DIR_OUT : DIR_IN;
                    end
                end
            end
            ST_ADDRESS: begin
                if (cpu_ds_s == ACTIVE) begin
                    state_d = ST_DATA;
                end else if (timeout) begin
                    state_d = ST_WAIT_FOR_CPU;
                    berr_d  = ACTIVE;
                end
            end
            ST_DATA: begin
                // A bus error outranks a simultaneous DTACK.
                if (vberr_s == ACTIVE) begin
                    state_d = ST_WAIT_FOR_CPU;
                    berr_d  = ACTIVE;
                end else if (dtack_s == ACTIVE) begin
                    state_d = ST_WAIT_FOR_CPU;
                    dsack_d = cycle_q.d32 ? DSACK_32 : DSACK_16;
                end else if (req_s == INACTIVE || timeout) begin
                    state_d = ST_WAIT_FOR_CPU;
                    berr_d  = ACTIVE;
                end
            end
            ST_WAIT_FOR_CPU: begin
                if (cpu_ds_s == INACTIVE && req_s == INACTIVE) begin
                    state_d = ST_IDLE;
                    cycle_d = CYCLE_IDLE;
                    dsack_d = DSACK_NONE;
                    berr_d  = INACTIVE;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cycle_d = CYCLE_IDLE;
                dsack_d = DSACK_NONE;
                berr_d  = INACTIVE;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            cycle_q <= CYCLE_IDLE;
            dsack_q <= DSACK_NONE;
            berr_q  <= INACTIVE;
        end else begin
            state_q <= state_d;
            cycle_q <= cycle_d;
            dsack_q <= dsack_d;
            berr_q  <= berr_d;
        end
    end

    logic bus_phase, data_phase;

    // All strobes and enables decode from registered state only.
    always_comb begin
        bus_phase       = (state_q == ST_ADDRESS) || (state_q == ST_DATA);
        data_phase      = (state_q == ST_DATA);
        vme_as          = bus_phase ? ACTIVE : INACTIVE;
        vme_ds          = data_phase ? cycle_q.ds : DS_NONE;
        vme_lword       = (bus_phase && cycle_q.d32) ? ACTIVE : INACTIVE;
        vme_write       = (bus_phase && cycle_q.write) ? ACTIVE : INACTIVE;
        vme_address_mod = cycle_q.am;
        addr_oe         = bus_phase ? ACTIVE : INACTIVE;
        data_high_oe    = data_phase ? ACTIVE : INACTIVE;
        data_low_oe     = (data_phase && cycle_q.d32) ? ACTIVE : INACTIVE;
        data_low_dir    = cycle_q.dir;
        data_high_dir   = cycle_q.dir;
        cpu_dsack       = dsack_q;
        cpu_berr        = berr_q;
        busy            = (state_q != ST_IDLE);
    end

endmodule

// File: tb/tb_vme_master_transfer.sv
// Directed bench for vme_master_transfer; a second instance with
// D32_SUPPORT=0 runs in lockstep to cover the D16-only build.
module tb_vme_master_transfer;

    logic       clock = 1'b0;
    logic       reset;
    logic       request_vme, bus_acquired, cpu_ds, cpu_write;
    logic [1:0] addr_space, cpu_siz, cpu_address;
    logic [2:0] cpu_fc;
    logic       vme_dtack, vme_berr;

    logic [1:0] cpu_dsack, vme_ds;
    logic       cpu_berr, vme_as, vme_lword, vme_write;
    logic [5:0] vme_address_mod;
    logic       addr_oe, data_low_oe, data_high_oe, data_low_dir, data_high_dir, busy;

    logic [1:0] cpu_dsack_16, vme_ds_16;
    logic       cpu_berr_16, vme_as_16, vme_lword_16, vme_write_16;
    logic [5:0] vme_address_mod_16;
    logic       addr_oe_16, data_low_oe_16, data_high_oe_16, data_low_dir_16, data_high_dir_16, busy_16;

    int checks = 0;
    int errors = 0;

    always #5 clock = ~clock;

    vme_master_transfer #(.SYNC_STAGES(2), .D32_SUPPORT(1), .TIMEOUT_CYCLES(16)) dut (
        .clock(clock), .reset(reset), .request_vme(request_vme), .addr_space(addr_space),
        .bus_acquired(bus_acquired), .cpu_ds(cpu_ds), .cpu_write(cpu_write), .cpu_siz(cpu_siz),
        .cpu_address(cpu_address), .cpu_fc(cpu_fc), .cpu_dsack(cpu_dsack), .cpu_berr(cpu_berr),
        .vme_as(vme_as), .vme_ds(vme_ds), .vme_lword(vme_lword), .vme_write(vme_write),
        .vme_address_mod(vme_address_mod), .vme_dtack(vme_dtack), .vme_berr(vme_berr),
        .addr_oe(addr_oe), .data_low_oe(data_low_oe), .data_high_oe(data_high_oe),
        .data_low_dir(data_low_dir), .data_high_dir(data_high_dir), .busy(busy)
    );

    vme_master_transfer #(.SYNC_STAGES(2), .D32_SUPPORT(0), .TIMEOUT_CYCLES(16)) dut16 (
        .clock(clock), .reset(reset), .request_vme(request_vme), .addr_space(addr_space),
        .bus_acquired(bus_acquired), .cpu_ds(cpu_ds), .cpu_write(cpu_write), .cpu_siz(cpu_siz),
        .cpu_address(cpu_address), .cpu_fc(cpu_fc), .cpu_dsack(cpu_dsack_16), .cpu_berr(cpu_berr_16),
        .vme_as(vme_as_16), .vme_ds(vme_ds_16), .vme_lword(vme_lword_16), .vme_write(vme_write_16),
        .vme_address_mod(vme_address_mod_16), .vme_dtack(vme_dtack), .vme_berr(vme_berr),
        .addr_oe(addr_oe_16), .data_low_oe(data_low_oe_16), .data_high_oe(data_high_oe_16),
        .data_low_dir(data_low_dir_16), .data_high_dir(data_high_dir_16), .busy(busy_16)
    );

    task automatic tick(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic idle_inputs();
        request_vme = 1'b1; bus_acquired = 1'b1; cpu_ds = 1'b1; cpu_write = 1'b1;
        vme_dtack = 1'b1; vme_berr = 1'b1;
        addr_space = 2'b00; cpu_siz = 2'b00; cpu_address = 2'b00; cpu_fc = 3'b001;
    endtask

    task automatic start_cycle(input logic [1:0] space, input logic [2:0] fc, input logic wr_n,
                               input logic [1:0] siz, input logic [1:0] a);
        addr_space = space; cpu_fc = fc; cpu_write = wr_n; cpu_siz = siz; cpu_address = a;
        request_vme = 1'b0; bus_acquired = 1'b0; cpu_ds = 1'b0;
    endtask

    // sel: 0 ADDRESS reached, 1 DATA reached, 2 WAIT_FOR_CPU reached, 3 IDLE reached
    task automatic wait_cond(input int sel, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            case (sel)
                0:       ok = (vme_as === 1'b0);
                1:       ok = (vme_ds !== 2'b11) && (vme_ds !== 2'bxx);
                2:       ok = (busy === 1'b1) && (vme_as === 1'b1);
                default: ok = (busy === 1'b0);
            endcase
            if (ok) break;
            tick(1);
        end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        idle_inputs();
        tick(3);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
        checks++; if (vme_as !== 1'b1) begin errors++; $display("FAIL reset_as got=%b exp=1", vme_as); end
        checks++; if (vme_ds !== 2'b11) begin errors++; $display("FAIL reset_ds got=%b exp=11", vme_ds); end
        checks++; if (cpu_dsack !== 2'b11) begin errors++; $display("FAIL reset_dsack got=%b exp=11", cpu_dsack); end
        checks++; if (cpu_berr !== 1'b1) begin errors++; $display("FAIL reset_berr got=%b exp=1", cpu_berr); end
        checks++; if (vme_address_mod !== 6'h3F) begin errors++; $display("FAIL reset_am got=%h exp=3f", vme_address_mod); end
        checks++; if ({data_high_dir, data_low_dir} !== 2'b00) begin errors++; $display("FAIL reset_dirs got=%b exp=00", {data_high_dir, data_low_dir}); end
        checks++; if ({addr_oe, data_high_oe, data_low_oe, vme_lword, vme_write} !== 5'b11111) begin
            errors++; $display("FAIL reset_strobes got=%b exp=11111", {addr_oe, data_high_oe, data_low_oe, vme_lword, vme_write}); end
        reset = 1'b1;
        tick(2);
    endtask

    task automatic test_a24_read();
        bit ok;
        start_cycle(2'b01, 3'b101, 1'b1, 2'b10, 2'b00);
        wait_cond(0, ok);
        checks++; if (!ok) begin errors++; $display("FAIL a24_address_wait got=%b exp=0", vme_as); end
        checks++; if (vme_address_mod !== 6'h3D) begin errors++; $display("FAIL a24_am got=%h exp=3d", vme_address_mod); end
        checks++; if ({data_high_dir, data_low_dir} !== 2'b11) begin errors++; $display("FAIL a24_dirs got=%b exp=11", {data_high_dir, data_low_dir}); end
        checks++; if ({addr_oe, data_high_oe, data_low_oe} !== 3'b011) begin errors++; $display("FAIL a24_oe_addr got=%b exp=011", {addr_oe, data_high_oe, data_low_oe}); end
        checks++; if ({vme_lword, vme_write} !== 2'b11) begin errors++; $display("FAIL a24_lword_write got=%b exp=11", {vme_lword, vme_write}); end
        wait_cond(1, ok);
        checks++; if (!ok) begin errors++; $display("FAIL a24_data_wait got=%b exp=00", vme_ds); end
        checks++; if (vme_ds !== 2'b00) begin errors++; $display("FAIL a24_ds got=%b exp=00", vme_ds); end
        checks++; if ({data_high_oe, data_low_oe} !== 2'b01) begin errors++; $display("FAIL a24_oe_data got=%b exp=01", {data_high_oe, data_low_oe}); end
        tick(5);
        checks++; if ({busy, vme_as, cpu_dsack} !== 4'b1011) begin errors++; $display("FAIL a24_hold got=%b exp=1011", {busy, vme_as, cpu_dsack}); end
        vme_dtack = 1'b0;
        wait_cond(2, ok);
        checks++; if (!ok) begin errors++; $display("FAIL a24_wait_state got=%b exp=1", vme_as); end
        checks++; if ({cpu_dsack, cpu_berr} !== 3'b011) begin errors++; $display("FAIL a24_dsack got=%b exp=011", {cpu_dsack, cpu_berr}); end
        checks++; if ({vme_ds, data_high_oe, data_low_oe} !== 4'b1111) begin errors++; $display("FAIL a24_release got=%b exp=1111", {vme_ds, data_high_oe, data_low_oe}); end
        idle_inputs();
        wait_cond(3, ok);
        checks++; if (!ok) begin errors++; $display("FAIL a24_idle_wait got=%b exp=0", busy); end
        checks++; if ({cpu_dsack, cpu_berr} !== 3'b111) begin errors++; $display("FAIL a24_idle_dsack got=%b exp=111", {cpu_dsack, cpu_berr}); end
        checks++; if (vme_address_mod !== 6'h3F) begin errors++; $display("FAIL a24_idle_am got=%h exp=3f", vme_address_mod); end
    endtask

    task automatic test_a32_long_write();
        bit ok;
        start_cycle(2'b10, 3'b001, 1'b0, 2'b00, 2'b00);
        wait_cond(0, ok);
        checks++; if (!ok) begin errors++; $display("FAIL a32_address_wait got=%b exp=0", vme_as); end
        checks++; if (vme_address_mod !== 6'h09) begin errors++; $display("FAIL a32_am got=%h exp=09", vme_address_mod); end
        checks++; if ({vme_lword, vme_write} !== 2'b00) begin errors++; $display("FAIL a32_lword_write got=%b exp=00", {vme_lword, vme_write}); end
        checks++; if ({data_high_dir, data_low_dir} !== 2'b00) begin errors++; $display("FAIL a32_dirs got=%b exp=00", {data_high_dir, data_low_dir}); end
        checks++; if (vme_lword_16 !== 1'b1) begin errors++; $display("FAIL a32_d16_lword got=%b exp=1", vme_lword_16); end
        wait_cond(1, ok);
        checks++; if ({vme_ds, data_high_oe, data_low_oe} !== 4'b0000) begin errors++; $display("FAIL a32_data got=%b exp=0000", {vme_ds, data_high_oe, data_low_oe}); end
        checks++; if ({data_high_oe_16, data_low_oe_16} !== 2'b01) begin errors++; $display("FAIL a32_d16_oe got=%b exp=01", {data_high_oe_16, data_low_oe_16}); end
        vme_dtack = 1'b0;
        wait_cond(2, ok);
        checks++; if (!ok) begin errors++; $display("FAIL a32_wait_state got=%b exp=1", vme_as); end
        checks++; if (cpu_dsack !== 2'b00) begin errors++; $display("FAIL a32_dsack got=%b exp=00", cpu_dsack); end
        checks++; if (cpu_dsack_16 !== 2'b01) begin errors++; $display("FAIL a32_d16_dsack got=%b exp=01", cpu_dsack_16); end
        idle_inputs();
        wait_cond(3, ok);
        checks++; if (!ok) begin errors++; $display("FAIL a32_idle_wait got=%b exp=0", busy); end
    endtask

    task automatic test_a16_byte();
        logic [2:0] fcs [2] = '{3'b001, 3'b101};
        logic [1:0] adr [2] = '{2'b01, 2'b00};
        logic [5:0] am  [2] = '{6'h29, 6'h2D};
        logic [1:0] ds  [2] = '{2'b10, 2'b01};
        bit ok;
        for (int v = 0; v < 2; v++) begin
            start_cycle(2'b00, fcs[v], 1'b0, 2'b01, adr[v]);
            wait_cond(0, ok);
            checks++; if (vme_address_mod !== am[v]) begin errors++; $display("FAIL a16_am[%0d] got=%h exp=%h", v, vme_address_mod, am[v]); end
            wait_cond(1, ok);
            checks++; if (vme_ds !== ds[v]) begin errors++; $display("FAIL a16_ds[%0d] got=%b exp=%b", v, vme_ds, ds[v]); end
            vme_dtack = 1'b0;
            wait_cond(2, ok);
            checks++; if (cpu_dsack !== 2'b01) begin errors++; $display("FAIL a16_dsack[%0d] got=%b exp=01", v, cpu_dsack); end
            idle_inputs();
            wait_cond(3, ok);
        end
    endtask

    task automatic test_berr_with_dtack();
        bit ok;
        start_cycle(2'b01, 3'b001, 1'b1, 2'b10, 2'b00);
        wait_cond(1, ok);
        vme_dtack = 1'b0;
        vme_berr  = 1'b0;
        wait_cond(2, ok);
        checks++; if (!ok) begin errors++; $display("FAIL berr_wait_state got=%b exp=1", vme_as); end
        checks++; if ({cpu_berr, cpu_dsack} !== 3'b011) begin errors++; $display("FAIL berr_dtack got=%b exp=011", {cpu_berr, cpu_dsack}); end
        idle_inputs();
        wait_cond(3, ok);
        checks++; if (cpu_berr !== 1'b1) begin errors++; $display("FAIL berr_idle got=%b exp=1", cpu_berr); end
    endtask

    task automatic test_illegal_cycle();
        logic [1:0] spaces [2] = '{2'b01, 2'b11};
        logic [2:0] fcs    [2] = '{3'b111, 3'b001};
        bit ok;
        bit saw_as;
        for (int v = 0; v < 2; v++) begin
            saw_as = 1'b0;
            start_cycle(spaces[v], fcs[v], 1'b1, 2'b10, 2'b00);
            for (int i = 0; i < 20; i++) begin
                if (vme_as === 1'b0) saw_as = 1'b1;
                if (cpu_berr === 1'b0) break;
                tick(1);
            end
            tick(2);
            if (vme_as === 1'b0) saw_as = 1'b1;
            checks++; if (cpu_berr !== 1'b0) begin errors++; $display("FAIL illegal_berr[%0d] got=%b exp=0", v, cpu_berr); end
            checks++; if (saw_as !== 1'b0) begin errors++; $display("FAIL illegal_as[%0d] got=%b exp=0", v, saw_as); end
            checks++; if ({busy, cpu_dsack, vme_ds} !== 5'b11111) begin errors++; $display("FAIL illegal_state[%0d] got=%b exp=11111", v, {busy, cpu_dsack, vme_ds}); end
            idle_inputs();
            wait_cond(3, ok);
            checks++; if (!ok || cpu_berr !== 1'b1) begin errors++; $display("FAIL illegal_idle[%0d] got=%b exp=1", v, cpu_berr); end
        end
    endtask

    task automatic test_withdraw();
        bit ok;
        start_cycle(2'b10, 3'b010, 1'b1, 2'b01, 2'b00);
        wait_cond(1, ok);
        request_vme = 1'b1;
        wait_cond(2, ok);
        checks++; if (!ok) begin errors++; $display("FAIL withdraw_wait got=%b exp=1", vme_as); end
        checks++; if ({cpu_berr, cpu_dsack} !== 3'b011) begin errors++; $display("FAIL withdraw_berr got=%b exp=011", {cpu_berr, cpu_dsack}); end
        idle_inputs();
        wait_cond(3, ok);
    endtask

    task automatic test_reset_mid_cycle();
        bit ok;
        start_cycle(2'b10, 3'b101, 1'b1, 2'b00, 2'b00);
        wait_cond(1, ok);
        checks++; if (!ok) begin errors++; $display("FAIL midrst_data got=%b exp=00", vme_ds); end
        reset = 1'b0;
        tick(1);
        checks++; if ({busy, vme_as, vme_ds, cpu_dsack, cpu_berr} !== 7'b0111111) begin
            errors++; $display("FAIL midrst_ctrl got=%b exp=0111111", {busy, vme_as, vme_ds, cpu_dsack, cpu_berr}); end
        checks++; if ({addr_oe, data_high_oe, data_low_oe, vme_lword, vme_write, data_high_dir, data_low_dir} !== 7'b1111100) begin
            errors++; $display("FAIL midrst_xcvr got=%b exp=1111100", {addr_oe, data_high_oe, data_low_oe, vme_lword, vme_write, data_high_dir, data_low_dir}); end
        checks++; if (vme_address_mod !== 6'h3F) begin errors++; $display("FAIL midrst_am got=%h exp=3f", vme_address_mod); end
        idle_inputs();
        tick(1);
        reset = 1'b1;
        tick(2);
    endtask

`ifdef VME_BUS_TIMEOUT_EN
    task automatic test_timeout();
        bit ok;
        int n;
        start_cycle(2'b01, 3'b001, 1'b1, 2'b10, 2'b00);
        wait_cond(0, ok);
        n = 0;
        while (cpu_berr !== 1'b0 && n < 40) begin
            tick(1);
            n++;
        end
        checks++; if (n != 16) begin errors++; $display("FAIL timeout_cycles got=%0d exp=16", n); end
        checks++; if ({vme_as, cpu_dsack} !== 3'b111) begin errors++; $display("FAIL timeout_release got=%b exp=111", {vme_as, cpu_dsack}); end
        idle_inputs();
        wait_cond(3, ok);
    endtask
`endif

    initial begin
        test_reset();
        test_a24_read();
        test_a32_long_write();
        test_a16_byte();
        test_berr_with_dtack();
        test_illegal_cycle();
        test_withdraw();
`ifdef VME_BUS_TIMEOUT_EN
        test_timeout();
`endif
        test_reset_mid_cycle();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
